// File: rtl/jtag_vector_player.sv
// Plays JTAG TMS/TDI vectors from a stimulus RAM with a programmable TCK period,
// optionally capturing TDO for each step into a second RAM.
`timescale 1ns/1ps
module jtag_vector_player #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       tck_width,
    input  logic [31:0]       tdo_delay,
    input  logic [31:0]       vector_start,
    input  logic [31:0]       vector_end,
    input  logic [31:0]       vector_number_repeat,
    output logic [ADDR_W-1:0] vector_1_addr,
    input  logic [7:0]        vector_1_rd_data,
    output logic [ADDR_W-1:0] vector_2_addr,
    output logic              vector_2_we,
    output logic [7:0]        vector_2_wr_data,
    input  logic              tdo,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    output logic              busy,
    output logic              done,
    output logic [31:0]       pass_count
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, LOW, HIGH} state_t;

    state_t            state_reg, state_next;
    logic [31:0]       cnt_reg, pass_reg;
    logic [ADDR_W-1:0] cur_reg, v2_addr_reg;
    logic              tck_reg, tms_reg, tdi_reg, cap_reg, smp_reg;
    logic              we_reg, done_reg, data_bit_reg;

    logic [31:0] w_last, smp_idx, p_eff;
    logic        at_end, smp_now, tdo_bit;
    logic        launch, step_end, finish;

    // Upper address bits and spare stimulus bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{vector_start[31:ADDR_W], vector_end[31:ADDR_W], vector_1_rd_data[7:3]};

    always_comb begin
        w_last  = (tck_width == 32'd0) ? 32'd0 : tck_width - 32'd1;
        smp_idx = (tdo_delay < w_last) ? tdo_delay : w_last;
        p_eff   = (vector_number_repeat == 32'd0) ? 32'd1 : vector_number_repeat;
        at_end  = (cur_reg == vector_end[ADDR_W-1:0]);
        smp_now = (state_reg == HIGH) && (cnt_reg == smp_idx);
        // The sample cycle may coincide with the last HIGH cycle, so bypass the register.
        tdo_bit = smp_now ? tdo : smp_reg;
    end

    always_comb begin
        state_next = state_reg;
        launch     = 1'b0;
        step_end   = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    launch     = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: state_next = LOAD;
            LOAD:  state_next = LOW;
            LOW: begin
                if (cnt_reg == w_last) state_next = HIGH;
            end
            HIGH: begin
                if (cnt_reg == w_last) begin
                    step_end = 1'b1;
                    if (!at_end || (pass_reg + 32'd1 < p_eff)) begin
                        state_next = FETCH;
                    end else begin
                        state_next = IDLE;
                        finish     = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort && state_reg != IDLE) begin
            state_next = IDLE;
            step_end   = 1'b0;
            finish     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 32'd0;
            pass_reg     <= 32'd0;
            cur_reg      <= '0;
            v2_addr_reg  <= '0;
            tck_reg      <= 1'b0;
            tms_reg      <= 1'b0;
            tdi_reg      <= 1'b0;
            cap_reg      <= 1'b0;
            smp_reg      <= 1'b0;
            we_reg       <= 1'b0;
            done_reg     <= 1'b0;
            data_bit_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= finish;
            we_reg    <= step_end && cap_reg;
            tck_reg   <= (state_next == HIGH);
            cnt_reg   <= ((state_reg == LOW || state_reg == HIGH) && state_next == state_reg)
                         ? cnt_reg + 32'd1 : 32'd0;
            if (smp_now) smp_reg <= tdo;
            if (state_reg == LOAD) begin
                tms_reg <= vector_1_rd_data[0];
                tdi_reg <= vector_1_rd_data[1];
                cap_reg <= vector_1_rd_data[2];
            end
            if (launch) begin
                cur_reg  <= vector_start[ADDR_W-1:0];
                pass_reg <= 32'd0;
            end else if (step_end) begin
                if (!at_end) begin
                    cur_reg <= cur_reg + 1'b1;
                end else begin
                    pass_reg <= pass_reg + 32'd1;
                    cur_reg  <= vector_start[ADDR_W-1:0];
                end
            end
            if (step_end && cap_reg) begin
                v2_addr_reg  <= cur_reg;
                data_bit_reg <= tdo_bit;
            end
        end
    end

    assign vector_1_addr    = cur_reg;
    assign vector_2_addr    = v2_addr_reg;
    assign vector_2_we      = we_reg;
    assign vector_2_wr_data = {7'b0, data_bit_reg};
    assign tck              = tck_reg;
    assign tms              = tms_reg;
    assign tdi              = tdi_reg;
    assign busy             = (state_reg != IDLE);
    assign done             = done_reg;
    assign pass_count       = pass_reg;
endmodule

// File: doc/jtag_vector_player.md
JTAG_VECTOR_PLAYER -- requirements
Module: jtag_vector_player

Interface
REQ-001 Parameter ADDR_W, default 12: vector RAM byte-address width.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle run request; ignored while busy.
REQ-005 abort  in  1  one-cycle stop request.
REQ-006 tck_width  in  32  TCK half-period in clk cycles.
REQ-007 tdo_delay  in  32  clk cycles after TCK rise at which TDO is sampled.
REQ-008 vector_start, vector_end  in  32 each  first and last vector byte address; only [ADDR_W-1:0] used.
REQ-009 vector_number_repeat  in  32  number of passes over the vector range.
REQ-010 vector_1_addr  out  ADDR_W  stimulus RAM read address.
REQ-011 vector_1_rd_data  in  8  stimulus byte, valid one cycle after its address (registered RAM): bit0 TMS, bit1 TDI, bit2 capture.
REQ-012 vector_2_addr  out  ADDR_W; vector_2_we  out  1; vector_2_wr_data  out  8  capture RAM write port.
REQ-013 tdo  in  1  JTAG TDO, already synchronised to clk.
REQ-014 tck, tms, tdi  out  1 each  registered JTAG drive.
REQ-015 busy  out  1; done  out  1 (one-cycle pulse); pass_count  out  32  completed passes.

Function
REQ-016 States: IDLE, FETCH, LOAD, LOW, HIGH.
- IDLE -> FETCH on start; loads cur_addr = vector_start, pass_count = 0.
- FETCH: drives vector_1_addr = cur_addr for one cycle -> LOAD.
- LOAD: latches tms = bit0, tdi = bit1, cap = bit2 -> LOW.
- LOW: tck = 0 for W cycles -> HIGH.
- HIGH: tck = 1 for W cycles.
REQ-017 W = tck_width, with tck_width = 0 treated as 1; each vector step lasts exactly 2 + 2*W cycles.
REQ-018 TDO sampling in HIGH:
- TDO is sampled on HIGH cycle index min(tdo_delay, W-1), counting from 0.
- If cap = 1, then on the cycle after the last HIGH cycle: vector_2_we = 1 for one cycle, vector_2_addr = cur_addr, vector_2_wr_data = {7'b0, sampled tdo}.
REQ-019 After the last HIGH cycle, when cur_addr != vector_end[ADDR_W-1:0]:
- cur_addr increments modulo 2^ADDR_W;
- -> FETCH.
- If vector_end < vector_start, the range wraps through address 0.
REQ-020 After the last HIGH cycle, when cur_addr == vector_end:
- pass_count increments.
- If pass_count + 1 < P, where P = max(vector_number_repeat, 1), then cur_addr = vector_start -> FETCH.
- Otherwise -> IDLE, with done = 1 for one cycle.
REQ-021 tms and tdi hold their values from LOAD until the next LOAD; in IDLE, tck = 0 and tms/tdi keep their last values.
REQ-022 busy = 1 in every state except IDLE, including the done cycle's predecessor; busy = 0 in the cycle done = 1.
REQ-023 abort in any non-IDLE state:
- -> IDLE next cycle, tck = 0, no done pulse, no vector_2 write for the interrupted step.
- abort has priority over start and over step completion.
REQ-024 start and abort asserted together in IDLE: remain IDLE.
REQ-025 Configuration inputs are sampled continuously; software holds them stable while busy.

Reset
REQ-026 reset forces IDLE and sets tck = tms = tdi = 0, busy = 0, done = 0, vector_2_we = 0, pass_count = 0, vector_1_addr = 0, vector_2_addr = 0; reset mid-run aborts with no write and no done.

Verification
REQ-027 Single step: tck_width = 2, start = end = 5, repeat = 1, RAM1[5] = 0x07, tdo = 1 -> one TCK pulse, high 2 cycles; tms = tdi = 1; vector_2 write at address 5 with data 0x01; done 6 cycles after FETCH begins.
REQ-028 Range with repeats: start = 0, end = 3, repeat = 2, tck_width = 1 -> 8 TCK pulses at addresses 0,1,2,3,0,1,2,3; pass_count ends at 2; one done pulse.
REQ-029 Wrap and degenerate values: start = 0xFFE, end = 0x001, tck_width = 0, repeat = 0 -> addresses 0xFFE, 0xFFF, 0x000, 0x001; every step lasts 4 cycles; a single pass.
REQ-030 TDO timing: tck_width = 4, tdo_delay = 9, tdo rises on HIGH index 3 only -> captured 1; with tdo_delay = 1, captured 0.
REQ-031 Abort and reset: abort asserted in HIGH of the second vector -> tck = 0 next cycle, no write for that step, no done. Repeat the run with reset instead of abort -> all outputs at reset values. A following start -> normal run.
REQ-032 start asserted while busy -> ignored, and the run completes unchanged; cap = 0 bytes -> vector_2_we never asserted.
